rsa_keygen_sequencer: RTL and testbench
=======================================

# rsa_keygen_sequencer

Multi-cycle controller that sequences RSA key generation from a pair of prime candidates. It fetches p and q from the prime generator over a request/valid handshake and computes n = p·q and L = (p−1)(q−1). It then searches for the smallest odd public exponent e ≥ 3 with gcd(e, L) = 1, and finds the private exponent d with e·d ≡ 1 (mod L). It replaces the free-running combinational key path with a deterministic FSM and presents n/e/d to the output stage with a done/fail status.

## Interface
- SIZE, 8, width of p, q, e; n, L, d are 2·SIZE bits
- MAX_RETRY, 4, rejected prime pairs tolerated before fail
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- st  in  1  start; sampled in IDLE and DONE/FAIL
- prime_req  out  1  request new p/q pair
- prime_valid  in  1  p_in/q_in valid this cycle
- p_in, q_in  in  SIZE  prime candidates
- n  out  2·SIZE  modulus
- e  out  SIZE  public exponent
- d  out  2·SIZE  private exponent
- busy  out  1  high in every state except IDLE, DONE, FAIL
- done  out  1  level, high in DONE
- fail  out  1  level, high in FAIL

## Operation
- States: IDLE, FETCH, CHECK, MUL, E_GCD, E_NEXT, D_SEARCH, DONE, FAIL.
- IDLE: st=1 → FETCH; clear retry count.
- FETCH: prime_req=1. On prime_valid=1, latch p_in/q_in → CHECK.
- CHECK: reject if p==q, p<3 or q<3. On reject, retry+1; if retry==MAX_RETRY → FAIL, else → FETCH. On accept → MUL, starting both multipliers.
- MUL: two shift-add multipliers run in parallel, p·q and (p−1)·(q−1). When both finish: n_r, L latched; e_cand=3 → E_GCD with a=L, b=e_cand.
- E_GCD: one subtract-Euclid step per cycle.
  - If b==0: a==1 → D_SEARCH with d_cnt=1, acc=e_cand; otherwise → E_NEXT.
  - Else if a≥b: a←a−b.
  - Else: swap a, b.
- E_NEXT: e_cand+=2. → FAIL if e_cand ≥ L or the add overflows SIZE bits. Otherwise reload a=L, b=e_cand → E_GCD.
- D_SEARCH: if acc==1 → DONE. Otherwise d_cnt+=1 and acc←acc+e_cand, subtracting L if the sum is ≥ L; accumulate at 2·SIZE+1 bits.
- DONE entry: n, e, d registers loaded. They hold until the next DONE entry or reset.
- DONE/FAIL: st=1 → FETCH (restart). st is ignored in all busy states.
- Primality of p_in/q_in is not checked; that is the generator's contract.

## Timing
- Reset values: n=0, e=0, d=0, done=0, fail=0, busy=0, prime_req=0; state IDLE.
- Reset mid-operation aborts immediately. Outputs return to 0, including previously published keys.
- st→prime_req: 1 cycle (IDLE→FETCH registered).
- prime_req stays high until the cycle prime_valid is seen. It drops the cycle after, and p/q are captured on that edge. prime_valid while prime_req=0 is ignored.
- CHECK: 1 cycle. MUL: exactly SIZE cycles. E_NEXT: 1 cycle.
- E_GCD: data-dependent, bounded by 2·2^(2·SIZE) cycles.
- D_SEARCH: exactly d cycles including the acc==1 test cycle.
- done/fail/busy are registered state decodes. n/e/d are valid in the same cycle done first rises.
- On restart from DONE, done falls 1 cycle after st and n/e/d keep their old values until the next DONE.

## Structure
- Shared package rsa_pkg: state enum, SIZE default, MAX_RETRY default, width helpers (SIZE, 2·SIZE).
- Sub-module seq_mult (SIZE×SIZE → 2·SIZE, start/done, SIZE-cycle shift-add), instantiated twice.
- GCD and modular-accumulate datapaths stay inline in the FSM module.

## Test plan
- p=11, q=13 after st → n=143, L=120. e tries 3 and 5, then settles on 7. d=103, done=1, fail=0.
- p=3, q=5 → n=15, e=3, d=3. D_SEARCH lasts exactly 3 cycles.
- Generator returns p=q=7 four times with MAX_RETRY=4 → fail=1, done=0, n/e/d remain 0.
- p=q=7 once, then p=11, q=13 → a second prime_req handshake occurs and the final keys are 143/7/103.
- Assert reset during E_GCD → all outputs 0 immediately and state IDLE. A new st reruns and yields the correct keys.
- While in DONE with 143/7/103, pulse st and supply p=3, q=5 → done drops and the old keys hold until the new DONE, then n=15, e=3, d=3.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA key generation sequencer.
// State encoding plus width helpers used by the FSM and multipliers.
package rsa_pkg;

  localparam int SIZE_DEF      = 8;
  localparam int MAX_RETRY_DEF = 4;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    CHECK,
    MUL,
    E_GCD,
    E_NEXT,
    D_SEARCH,
    DONE,
    FAIL
  } state_t;

  function automatic int nw(input int s);
    return s;
  endfunction

  function automatic int ww(input int s);
    return 2 * s;
  endfunction

endpackage

// File: rtl/rsa_keygen_sequencer_mult.sv
// Shift-add multiplier, SIZE x SIZE -> 2*SIZE, one bit per cycle.
// done is high in the last iteration cycle; p carries the final sum.
module seq_mult
  import rsa_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIZE-1:0]      a,
  input  logic [SIZE-1:0]      b,
  output logic                 done,
  output logic [2*SIZE-1:0]    p
);

  localparam int CW = $clog2(SIZE + 1);

  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] mcand;
  logic [SIZE-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic [2*SIZE-1:0] acc_nxt;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign p       = acc_nxt;
  assign done    = (cnt == CW'(1));

  // load operands on start, then one partial product per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{SIZE{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(SIZE);
    end else if (cnt != '0) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rsa_keygen_sequencer.sv
// RSA key generation sequencer: fetch p/q, multiply, search e, search d.
// Publishes n/e/d on DONE entry; they hold until the next DONE or reset.
module rsa_keygen_sequencer
  import rsa_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st,
  output logic              prime_req,
  input  logic              prime_valid,
  input  logic [SIZE-1:0]   p_in,
  input  logic [SIZE-1:0]   q_in,
  output logic [2*SIZE-1:0] n,
  output logic [SIZE-1:0]   e,
  output logic [2*SIZE-1:0] d,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int W  = ww(SIZE);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t state, nstate;

  logic [SIZE-1:0] p_r, q_r, e_cand;
  logic [W-1:0]    n_r, l_r, a, b, d_cnt;
  logic [W:0]      acc, acc_sum, acc_red;
  logic [RW-1:0]   retry, retry_inc;
  logic [SIZE:0]   e_sum;
  logic            reject, retry_max, e_bad;
  logic            mul_go, n_done, l_done;
  logic [W-1:0]    n_prod, l_prod;

  assign reject    = (p_r == q_r) || (p_r < SIZE'(3))
                     || (q_r < SIZE'(3));
  assign retry_inc = retry + RW'(1);
  assign retry_max = (retry_inc == RW'(MAX_RETRY));
  assign e_sum     = {1'b0, e_cand} + (SIZE+1)'(2);
  assign e_bad     = e_sum[SIZE]
                     || (W'(e_sum[SIZE-1:0]) >= l_r);
  assign acc_sum   = acc + (W+1)'(e_cand);
  assign acc_red   = (acc_sum >= {1'b0, l_r})
                     ? acc_sum - {1'b0, l_r} : acc_sum;

  assign busy = !(state inside {IDLE, DONE, FAIL});
  assign done = (state == DONE);
  assign fail = (state == FAIL);

  seq_mult #(.SIZE(SIZE)) u_mul_n (
    .clk   (clk),
    .reset (reset),
    .start (mul_go),
    .a     (p_r),
    .b     (q_r),
    .done  (n_done),
    .p     (n_prod)
  );

  seq_mult #(.SIZE(SIZE)) u_mul_l (
    .clk   (clk),
    .reset (reset),
    .start (mul_go),
    .a     (p_r - SIZE'(1)),
    .b     (q_r - SIZE'(1)),
    .done  (l_done),
    .p     (l_prod)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // next-state and handshake/multiplier-start decode
  always_comb begin
    nstate    = state;
    prime_req = 1'b0;
    mul_go    = 1'b0;
    unique case (state)
      IDLE:     if (st) nstate = FETCH;
      FETCH: begin
        prime_req = 1'b1;
        if (prime_valid) nstate = CHECK;
      end
      CHECK: begin
        if (reject) begin
          nstate = retry_max ? FAIL : FETCH;
        end else begin
          mul_go = 1'b1;
          nstate = MUL;
        end
      end
      MUL:      if (n_done && l_done) nstate = E_GCD;
      E_GCD: begin
        if (b == '0)
          nstate = (a == W'(1)) ? D_SEARCH : E_NEXT;
      end
      E_NEXT:   nstate = e_bad ? FAIL : E_GCD;
      D_SEARCH: if (acc == (W+1)'(1)) nstate = DONE;
      DONE:     if (st) nstate = FETCH;
      FAIL:     if (st) nstate = FETCH;
      default:  nstate = IDLE;
    endcase
  end

  // datapath: operand capture, Euclid steps, modular accumulate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_r    <= '0;
      q_r    <= '0;
      n_r    <= '0;
      l_r    <= '0;
      a      <= '0;
      b      <= '0;
      e_cand <= '0;
      d_cnt  <= '0;
      acc    <= '0;
      retry  <= '0;
      n      <= '0;
      e      <= '0;
      d      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, FAIL: if (st) retry <= '0;
        FETCH: begin
          if (prime_valid) begin
            p_r <= p_in;
            q_r <= q_in;
          end
        end
        CHECK: if (reject) retry <= retry_inc;
        MUL: begin
          if (n_done && l_done) begin
            n_r    <= n_prod;
            l_r    <= l_prod;
            a      <= l_prod;
            b      <= W'(3);
            e_cand <= SIZE'(3);
          end
        end
        E_GCD: begin
          if (b == '0) begin
            d_cnt <= W'(1);
            acc   <= (W+1)'(e_cand);
          end else if (a >= b) begin
            a <= a - b;
          end else begin
            a <= b;
            b <= a;
          end
        end
        E_NEXT: begin
          e_cand <= e_sum[SIZE-1:0];
          a      <= l_r;
          b      <= W'(e_sum[SIZE-1:0]);
        end
        D_SEARCH: begin
          if (acc == (W+1)'(1)) begin
            n <= n_r;
            e <= e_cand;
            d <= d_cnt;
          end else begin
            d_cnt <= d_cnt + W'(1);
            acc   <= acc_red;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_sequencer.sv
// Directed bench for rsa_keygen_sequencer with hand-computed keys.
// Immediate assertions at each check point; one summary line at the end.
module tb_rsa_keygen_sequencer;
  import rsa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st;
  logic        prime_valid;
  logic [7:0]  p_in, q_in;
  logic        prime_req;
  logic [15:0] n, d;
  logic [7:0]  e;
  logic        busy, done, fail;

  int total = 0;
  int bad   = 0;
  int cyc, dsc;
  int rises = 0;
  int r0;
  logic prev_req = 1'b0;

  rsa_keygen_sequencer #(.SIZE(8), .MAX_RETRY(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .st          (st),
    .prime_req   (prime_req),
    .prime_valid (prime_valid),
    .p_in        (p_in),
    .q_in        (q_in),
    .n           (n),
    .e           (e),
    .d           (d),
    .busy        (busy),
    .done        (done),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prime_req && !prev_req) rises++;
    prev_req <= prime_req;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_st;
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic serve(input logic [7:0] pv, input logic [7:0] qv);
    int k;
    k = 0;
    while (!prime_req && k < 50) begin
      tick();
      k++;
    end
    chk("req_seen", {31'b0, prime_req}, 1);
    p_in        = pv;
    q_in        = qv;
    prime_valid = 1'b1;
    tick();
    prime_valid = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    cyc = 0;
    dsc = 0;
    while (!(done || fail) && cyc < bound) begin
      tick();
      cyc++;
      if (dut.state == D_SEARCH) dsc++;
    end
    chk("end_seen", {31'b0, done | fail}, 1);
  endtask

  task automatic chk_keys(input string tag, input int nx,
                          input int ex, input int dx);
    chk({tag, "_n"}, 32'(n), nx);
    chk({tag, "_e"}, 32'(e), ex);
    chk({tag, "_d"}, 32'(d), dx);
  endtask

  initial begin
    int k;
    reset       = 1'b1;
    st          = 1'b0;
    prime_valid = 1'b0;
    p_in        = '0;
    q_in        = '0;
    repeat (2) tick();
    chk_keys("rst", 0, 0, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_fail", {31'b0, fail}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_req", {31'b0, prime_req}, 0);
    reset = 1'b0;
    prime_valid = 1'b1;
    tick();
    chk("ign_valid", {31'b0, prime_req}, 0);
    prime_valid = 1'b0;

    // 11 x 13: L=120, e=7, d=103
    pulse_st();
    chk("st_req", {31'b0, prime_req}, 1);
    chk("st_busy", {31'b0, busy}, 1);
    serve(8'd11, 8'd13);
    chk("req_drop", {31'b0, prime_req}, 0);
    wait_end(2000);
    chk_keys("k1", 143, 7, 103);
    chk("k1_done", {31'b0, done}, 1);
    chk("k1_fail", {31'b0, fail}, 0);
    chk("k1_busy", {31'b0, busy}, 0);
    chk("k1_dcyc", dsc, 103);

    // restart from DONE with 3 x 5
    pulse_st();
    chk("rs_done", {31'b0, done}, 0);
    chk_keys("rs_hold", 143, 7, 103);
    serve(8'd3, 8'd5);
    repeat (5) tick();
    chk_keys("rs_mid", 143, 7, 103);
    wait_end(2000);
    chk("k2_lat", cyc + 5, 21);
    chk("k2_dcyc", dsc, 3);
    chk_keys("k2", 15, 3, 3);

    // one rejected pair then a good one
    r0 = rises;
    pulse_st();
    serve(8'd7, 8'd7);
    serve(8'd11, 8'd13);
    wait_end(2000);
    chk("k3_hs", rises - r0, 2);
    chk_keys("k3", 143, 7, 103);

    // four rejected pairs after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_st();
    for (int i = 0; i < 4; i++) serve(8'd7, 8'd7);
    tick();
    chk("f_fail", {31'b0, fail}, 1);
    chk("f_done", {31'b0, done}, 0);
    chk("f_busy", {31'b0, busy}, 0);
    chk_keys("f", 0, 0, 0);

    // reset while in E_GCD, then rerun
    pulse_st();
    serve(8'd11, 8'd13);
    k = 0;
    while (dut.state != E_GCD && k < 100) begin
      tick();
      k++;
    end
    chk("in_gcd", 32'(dut.state), 32'(E_GCD));
    reset = 1'b1;
    #1;
    chk("ar_state", 32'(dut.state), 32'(IDLE));
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_req", {31'b0, prime_req}, 0);
    chk("ar_done", {31'b0, done | fail}, 0);
    chk_keys("ar", 0, 0, 0);
    tick();
    reset = 1'b0;
    pulse_st();
    serve(8'd11, 8'd13);
    wait_end(2000);
    chk_keys("k4", 143, 7, 103);
    chk("k4_done", {31'b0, done}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
